fan_ramp_sequencer: RTL
=======================

Name: fan_ramp_sequencer

Overview:
Closed-loop fan sequencer downstream of the temperature sensor interface. It maps sampled temperature to a LOW/MED/HIGH speed level, applying hysteresis on falling temperature. It sequences the fan through spin-up kick, rate-limited duty ramping and hold, and drives a glitch-free PWM output. The settled speed level is reported on fan_speed, using the same 2-bit level semantics as the existing temperature-to-fan mapping (below 20 = low, 20..40 = medium, above 40 = high).

Parameters:
PWM_BITS, 8, duty and PWM counter width
DUTY_LOW, 64, target duty for LOW
DUTY_MED, 160, target duty for MED
DUTY_HIGH, 255, target duty for HIGH
T_MED, 20, rising threshold into MED (temp >= T_MED)
T_HIGH, 40, rising threshold into HIGH (temp > T_HIGH)
HYST, 2, falling hysteresis in degrees
RAMP_DIV, 4, clock cycles per 1-LSB duty step
KICK_CYCLES, 16, spin-up cycles at full duty
STALL_TIMEOUT, 1024, tach timeout in cycles (optional feature only)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
temp_in  in  8  unsigned temperature sample
temp_valid  in  1  one-cycle strobe; temp_in is valid in that cycle
tach_pulse  in  1  one-cycle tach pulse (used only with optional feature)
fan_speed  out  2  settled level: 00 LOW, 01 MED, 10 HIGH (11 never driven)
pwm_out  out  1  PWM drive
busy  out  1  high in KICK or RAMP
stall_err  out  1  sticky stall flag

Behaviour:
- Reset (async assert, sync release): state IDLE, target level LOW, duty_cur 0, shadow duty 0, PWM counter 0, fan_speed 00, pwm_out 0, busy 0, stall_err 0. Asserting rst_n mid-operation forces all outputs to these values immediately.
- Level update is evaluated only when temp_valid=1. The new target level takes effect on the next cycle. Falling thresholds saturate at 0.
  - From LOW: temp > T_HIGH -> HIGH; else temp >= T_MED -> MED.
  - From MED: temp > T_HIGH -> HIGH; temp < T_MED-HYST -> LOW.
  - From HIGH: temp < T_MED-HYST -> LOW; temp <= T_HIGH-HYST -> MED.
- duty_tgt is the DUTY_x value of the current target level.
- FSM:
  - IDLE: wait for the first temp_valid after reset, then go to KICK.
  - KICK: duty_cur = 2^PWM_BITS-1 for exactly KICK_CYCLES cycles, then RAMP. temp_valid during KICK updates the target but does not shorten the kick.
  - RAMP: a tick fires every RAMP_DIV cycles; the divider is cleared on RAMP entry. On each tick, duty_cur moves 1 LSB toward duty_tgt. In any cycle where duty_cur == duty_tgt with no level change in that cycle, go to HOLD next cycle. A level change always takes priority and the FSM stays in RAMP. The ramp direction is re-evaluated every tick.
  - HOLD: fan_speed is loaded with the target level on HOLD entry. A later target change with duty_tgt != duty_cur goes to RAMP; fan_speed keeps its old value until the next HOLD entry.
- PWM: the counter runs 0..2^PWM_BITS-2 and wraps, giving a period of 2^PWM_BITS-1. The shadow duty is loaded from duty_cur only when counter == 0. pwm_out = (counter < shadow), registered. Duty 0 gives a constant 0; duty 2^PWM_BITS-1 gives a constant 1.
- All arithmetic is unsigned. Duty never wraps; the ramp stops exactly at duty_tgt.

Optional Feature:
FAN_STALL_DETECT_EN
- Defined: in HOLD with duty_cur != 0, a counter counts cycles since the last tach_pulse. Reaching STALL_TIMEOUT sets stall_err (sticky until reset) and forces KICK, then RAMP back to the same target. tach_pulse clears the counter. The counter is cleared on every HOLD entry.
- Undefined: tach_pulse is ignored and stall_err is tied to 0.

Decomposition:
- Package fan_ctrl_pkg: level encodings (LVL_LOW=2'b00, LVL_MED=2'b01, LVL_HIGH=2'b10) and the FSM state encoding (IDLE, KICK, RAMP, HOLD).
- Sub-module fan_pwm_gen (params PWM_BITS): counter, shadow register and comparator; inputs clk, rst_n, duty; output pwm_out.

Test Plan:
- Reset, then temp_in=10 strobe -> busy=1; pwm_out constant 1 for 16 cycles; duty ramps 255->64 over 764 cycles; HOLD; fan_speed=00, busy=0; PWM high 64 of every 255 cycles.
- From LOW hold, strobe 25 then 40 -> fan_speed=01 after ramp 64->160 (384 cycles); the 40 causes no change. Strobe 41 -> ramp to 255, fan_speed=10.
- Hysteresis from HIGH: strobe 39 -> stays HIGH; 38 -> MED; 18 -> stays MED; 17 -> LOW. Boundaries 20 (rising, from LOW) -> MED and 41 -> HIGH.
- Strobe 50 mid-ramp from 64 toward 160 -> ramp continues to 255 without entering HOLD; fan_speed stays 00 until HOLD, then 10.
- rst_n low mid-RAMP -> all outputs 0 in the same cycle. After release, no PWM activity until the next temp_valid.
- With FAN_STALL_DETECT_EN, STALL_TIMEOUT=1024: hold at MED with no tach -> stall_err=1 at cycle 1024, KICK re-entered. Tach every 500 cycles -> stall_err stays 0.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: speed level and FSM state encodings plus the hysteresis level mapping
// shared by the fan ramp sequencer.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        LVL_LOW  = 2'b00,
        LVL_MED  = 2'b01,
        LVL_HIGH = 2'b10
    } lvl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KICK,
        ST_RAMP,
        ST_HOLD
    } state_t;

    // Rising thresholds apply directly; falling ones are lowered by hyst, floored at 0.
    function automatic lvl_t next_level(lvl_t cur, logic [7:0] t, logic [7:0] med,
                                        logic [7:0] high, logic [7:0] hyst);
        logic [7:0] med_f;
        logic [7:0] high_f;
        med_f  = (med > hyst) ? med - hyst : 8'd0;
        high_f = (high > hyst) ? high - hyst : 8'd0;
        return (cur == LVL_MED)  ? ((t > high) ? LVL_HIGH : (t < med_f) ? LVL_LOW : LVL_MED) :
               (cur == LVL_HIGH) ? ((t < med_f) ? LVL_LOW : (t <= high_f) ? LVL_MED : LVL_HIGH) :
                                   ((t > high) ? LVL_HIGH : (t >= med) ? LVL_MED : LVL_LOW);
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: free-running PWM with a shadow duty register reloaded at the start
// of each 2^PWM_BITS-1 cycle period, so duty changes never glitch mid-period.
module fan_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d    = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
        shadow_d = (cnt_q == '0) ? duty : shadow_q;
        pwm_d    = cnt_q < shadow_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/fan_ramp_sequencer.sv
// fan_ramp_sequencer: temperature-to-level mapping with hysteresis, spin-up kick, rate-limited
// duty ramp and hold. Optional stall detection is enabled by defining FAN_STALL_DETECT_EN.
module fan_ramp_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int DUTY_LOW      = 64,
    parameter int DUTY_MED      = 160,
    parameter int DUTY_HIGH     = 255,
    parameter int T_MED         = 20,
    parameter int T_HIGH        = 40,
    parameter int HYST          = 2,
    parameter int RAMP_DIV      = 4,
    parameter int KICK_CYCLES   = 16,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] temp_in,
    input  logic       temp_valid,
    input  logic       tach_pulse,
    output logic [1:0] fan_speed,
    output logic       pwm_out,
    output logic       busy,
    output logic       stall_err
);

    localparam int KW = $clog2(KICK_CYCLES + 1);
    localparam int DW = $clog2(RAMP_DIV + 1);
    localparam logic [PWM_BITS-1:0] D_MAX  = '1;
    localparam logic [PWM_BITS-1:0] D_LOW  = PWM_BITS'(DUTY_LOW);
    localparam logic [PWM_BITS-1:0] D_MED  = PWM_BITS'(DUTY_MED);
    localparam logic [PWM_BITS-1:0] D_HIGH = PWM_BITS'(DUTY_HIGH);

    state_t              state_q, state_d;
    lvl_t                level_q, level_d, speed_q, speed_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, duty_tgt;
    logic [KW-1:0]       kick_q, kick_d;
    logic [DW-1:0]       div_q, div_d;
    logic                tick, lvl_chg;

`ifdef FAN_STALL_DETECT_EN
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
`else
    logic unused_tach;
    assign unused_tach = tach_pulse;
`endif

    always_comb begin
        level_d  = temp_valid ? next_level(level_q, temp_in, 8'(T_MED), 8'(T_HIGH), 8'(HYST)) : level_q;
        lvl_chg  = level_d != level_q;
        duty_tgt = (level_q == LVL_HIGH) ? D_HIGH : (level_q == LVL_MED) ? D_MED : D_LOW;
        tick     = div_q == DW'(RAMP_DIV - 1);
        state_d  = state_q;
        duty_d   = duty_q;
        kick_d   = kick_q;
        div_d    = div_q;
        speed_d  = speed_q;
`ifdef FAN_STALL_DETECT_EN
        stall_d  = stall_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (temp_valid) begin
                    state_d = ST_KICK;
                    duty_d  = D_MAX;
                    kick_d  = '0;
                end
            end
            ST_KICK: begin
                if (kick_q == KW'(KICK_CYCLES - 1)) begin
                    state_d = ST_RAMP;
                    div_d   = '0;
                end else begin
                    kick_d = kick_q + 1'b1;
                end
            end
            ST_RAMP: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick && duty_q != duty_tgt)
                    duty_d = (duty_q < duty_tgt) ? duty_q + 1'b1 : duty_q - 1'b1;
                if (duty_q == duty_tgt && !lvl_chg) begin
                    state_d = ST_HOLD;
                    speed_d = level_q;
`ifdef FAN_STALL_DETECT_EN
                    stall_d = '0;
`endif
                end
            end
            ST_HOLD: begin
                if (duty_tgt != duty_q) begin
                    state_d = ST_RAMP;
                    div_d   = '0;
                end
`ifdef FAN_STALL_DETECT_EN
                else if (duty_q != '0) begin
                    if (tach_pulse) begin
                        stall_d = '0;
                    end else if (stall_q == SW'(STALL_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_KICK;
                        duty_d  = D_MAX;
                        kick_d  = '0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= LVL_LOW;
            speed_q <= LVL_LOW;
            duty_q  <= '0;
            kick_q  <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            speed_q <= speed_d;
            duty_q  <= duty_d;
            kick_q  <= kick_d;
            div_q   <= div_d;
        end
    end

`ifdef FAN_STALL_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
    assign stall_err = err_q;
`else
    assign stall_err = 1'b0;
`endif

    fan_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty   (duty_q),
        .pwm_out(pwm_out)
    );

    assign fan_speed = speed_q;
    assign busy      = (state_q == ST_KICK) || (state_q == ST_RAMP);

endmodule
